// File: rtl/window_7x7_gen.sv
// rtl/window_7x7_gen.sv - 7x7 raster sliding-window generator with six line buffers
// Optional macro WINDOW_COORD_EN adds win_row/win_col centre-pixel coordinate outputs.
module window_7x7_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  input  logic         frame_start,
  output logic [391:0] window_out,
  output logic         window_valid,
  output logic         frame_done
`ifdef WINDOW_COORD_EN
  ,
  output logic [15:0]  win_row,
  output logic [15:0]  win_col
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic          last_col, last_row, win_hit;

  logic [7:0] line_buf [6][IMG_WIDTH];
  logic [7:0] win      [7][7];
  logic [7:0] new_col  [7];

  // frame_start overrides the counters so the qualifying pixel lands at (0,0)
  always_comb begin
    eff_col  = frame_start ? '0 : col;
    eff_row  = frame_start ? '0 : row;
    last_col = (eff_col == CW'(IMG_WIDTH - 1));
    last_row = (eff_row == RW'(IMG_HEIGHT - 1));
    win_hit  = (eff_row >= RW'(6)) && (eff_col >= CW'(6));
    new_col[6] = pix_in;
    for (int k = 0; k < 6; k++) begin
      new_col[5-k] = line_buf[k][eff_col];
    end
  end

  // Line buffers are never reset; window_valid gating hides stale contents
  always_ff @(posedge clk) begin
    if (!rst && pix_valid) begin
      line_buf[0][eff_col] <= pix_in;
      for (int k = 1; k < 6; k++) begin
        line_buf[k][eff_col] <= line_buf[k-1][eff_col];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        for (int j = 0; j < 7; j++) begin
          win[i][j] <= '0;
        end
      end
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (pix_valid) begin
        for (int i = 0; i < 7; i++) begin
          for (int j = 0; j < 6; j++) begin
            win[i][j] <= win[i][j+1];
          end
          win[i][6] <= new_col[i];
        end
        window_valid <= win_hit;
        frame_done   <= last_col && last_row;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : eff_row + RW'(1);
        end else begin
          col <= eff_col + CW'(1);
          row <= eff_row;
        end
      end
    end
  end

`ifdef WINDOW_COORD_EN
  // Centre of the window is three rows up and three columns left of the newest pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      win_row <= '0;
      win_col <= '0;
    end else if (pix_valid && win_hit) begin
      win_row <= 16'(eff_row) - 16'd3;
      win_col <= 16'(eff_col) - 16'd3;
    end
  end
`endif

  for (genvar gi = 0; gi < 7; gi++) begin : g_row
    for (genvar gj = 0; gj < 7; gj++) begin : g_col
      assign window_out[391 - 8*(7*gi + gj) -: 8] = win[gi][gj];
    end
  end

endmodule

// File: tb/tb_window_7x7_gen.sv
// tb/tb_window_7x7_gen.sv - randomized and directed bench for window_7x7_gen against an image-array model
module tb_window_7x7_gen;
  localparam int W = 8;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pix_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [7:0]   pix_in = '0;
  logic [391:0] window_out;
  logic         window_valid;
  logic         frame_done;
`ifdef WINDOW_COORD_EN
  logic [15:0]  win_row;
  logic [15:0]  win_col;
`endif

  always #5 clk = ~clk;

  window_7x7_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .window_out  (window_out),
    .window_valid(window_valid),
    .frame_done  (frame_done)
`ifdef WINDOW_COORD_EN
    ,
    .win_row     (win_row),
    .win_col     (win_col)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the frame as a plain 2D image plus the next expected position
  int           img [H][W];
  int           m_row, m_col;
  logic         m_wv, m_fd;
  logic [391:0] m_win;
  bit           m_win_known;
  int           m_wrow, m_wcol;
  int           wv_count, fd_count;

  task automatic check(input string tag, input logic [391:0] got, input logic [391:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_a(input logic [391:0] w, input int i, input int j);
    return w[391 - 8*(7*i + j) -: 8];
  endfunction

  task automatic step(input bit r, input bit v, input bit fs, input logic [7:0] p);
    int er, ec;
    rst = r; pix_valid = v; frame_start = fs; pix_in = p;
    @(posedge clk);
    if (r) begin
      m_row = 0; m_col = 0; m_wv = 0; m_fd = 0;
      m_win = '0; m_win_known = 1; m_wrow = 0; m_wcol = 0;
    end else if (v) begin
      er = fs ? 0 : m_row;
      ec = fs ? 0 : m_col;
      img[er][ec] = p;
      m_wv = (er >= 6 && ec >= 6);
      m_fd = (er == H-1 && ec == W-1);
      if (m_wv) begin
        for (int i = 0; i < 7; i++)
          for (int j = 0; j < 7; j++)
            m_win[391 - 8*(7*i + j) -: 8] = 8'(img[er-6+i][ec-6+j]);
        m_win_known = 1;
        m_wrow = er - 3;
        m_wcol = ec - 3;
      end else begin
        m_win_known = 0;
      end
      ec = ec + 1;
      if (ec == W) begin
        ec = 0;
        er = (er == H-1) ? 0 : er + 1;
      end
      m_row = er;
      m_col = ec;
    end else begin
      m_wv = 0;
      m_fd = 0;
    end
    #1;
    check("window_valid", window_valid, m_wv);
    check("frame_done", frame_done, m_fd);
    if (m_win_known) check("window_out", window_out, m_win);
`ifdef WINDOW_COORD_EN
    check("win_row", win_row, m_wrow);
    check("win_col", win_col, m_wcol);
`endif
    if (window_valid) wv_count++;
    if (frame_done) fd_count++;
  endtask

  task automatic px(input bit fs, input int offset);
    int er, ec;
    er = fs ? 0 : m_row;
    ec = fs ? 0 : m_col;
    step(0, 1, fs, 8'(er*W + ec + offset));
  endtask

  task automatic idle();
    step(0, 0, 0, 8'($urandom));
  endtask

  initial begin
    int first_n;
    m_row = 0; m_col = 0; m_wv = 0; m_fd = 0; m_win = '0; m_win_known = 0;
    m_wrow = 0; m_wcol = 0; wv_count = 0; fd_count = 0;

    repeat (3) step(1, 0, 0, 8'h00);
    check("rst_window_out", window_out, 0);

    // Frame 1, continuous
    wv_count = 0; fd_count = 0;
    for (int k = 0; k < 64; k++) begin
      px(k == 0, 0);
      if (k == 54) begin
        check("f1_valid_54", window_valid, 1);
        check("f1_a00", get_a(window_out, 0, 0), 0);
        check("f1_a66", get_a(window_out, 6, 6), 54);
        check("f1_a33", get_a(window_out, 3, 3), 27);
`ifdef WINDOW_COORD_EN
        check("f1_first_row", win_row, 3);
        check("f1_first_col", win_col, 3);
`endif
      end
      if (k == 53) check("f1_valid_53", window_valid, 0);
      if (k == 63) begin
        check("f1_done_63", frame_done, 1);
`ifdef WINDOW_COORD_EN
        check("f1_last_row", win_row, 4);
        check("f1_last_col", win_col, 4);
`endif
      end
    end
    idle();
    check("f1_wv_count", wv_count, 4);
    check("f1_fd_count", fd_count, 1);

    // Stall after pixel 54
    for (int k = 0; k < 64; k++) begin
      px(k == 0, 0);
      if (k == 54) begin
        repeat (3) begin
          idle();
          check("stall_wv", window_valid, 0);
          check("stall_a66", get_a(window_out, 6, 6), 54);
        end
      end
      if (k == 55) begin
        check("post_stall_a66", get_a(window_out, 6, 6), 55);
        check("post_stall_a00", get_a(window_out, 0, 0), 1);
      end
    end
    idle();

    // frame_start mid-frame at position (3,2)
    for (int k = 0; k < 26; k++) px(k == 0, 0);
    first_n = 0;
    px(1, 0);
    if (window_valid) first_n = 1;
    for (int n = 2; n <= 64; n++) begin
      px(0, 0);
      if (window_valid && first_n == 0) first_n = n;
    end
    check("fs_first_window", first_n, 55);
    idle();

    // Reset after pixel 58, then fresh frame without frame_start
    for (int k = 0; k <= 58; k++) px(k == 0, 0);
    step(1, 1, 1, 8'hA5);
    check("rst_mid_wv", window_valid, 0);
    check("rst_mid_win", window_out, 0);
    wv_count = 0; fd_count = 0;
    for (int k = 0; k < 64; k++) begin
      px(0, 0);
      if (k == 54) begin
        check("r_a00", get_a(window_out, 0, 0), 0);
        check("r_a66", get_a(window_out, 6, 6), 54);
        check("r_a33", get_a(window_out, 3, 3), 27);
      end
    end
    idle();
    check("r_wv_count", wv_count, 4);
    check("r_fd_count", fd_count, 1);

    // Two back-to-back frames; first one offset so leakage shows up
    wv_count = 0; fd_count = 0;
    for (int k = 0; k < 128; k++) begin
      px(k % 64 == 0, (k < 64) ? 128 : 0);
      if (k == 64 + 54) begin
        check("b2b_a00", get_a(window_out, 0, 0), 0);
        check("b2b_a06", get_a(window_out, 0, 6), 6);
      end
    end
    idle();
    check("b2b_wv_count", wv_count, 8);
    check("b2b_fd_count", fd_count, 2);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bit r, v, fs;
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 9) < 7);
      fs = v && ($urandom_range(0, 149) == 0);
      step(r, v, fs, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
